ddr_pkt_reader: RTL and testbench

- Downstream companion of the MRMAC-to-DDR packet writer. Replays packets the writer has committed to DDR onto a 512-bit AXI-stream, in write order.
- Packet layout in DDR matches the writer's:
  - Each packet starts on a beat boundary and is padded to whole beats.
  - Packets are stored back-to-back from BASE_ADDR.
  - Packet length is the big-endian 16-bit field {beat0[135:128], beat0[143:136]}.
- The block acts as an AXI4 read master: a header read, then a body burst, then AXI-stream output with tkeep/tlast.

---
 rtl/ddr_pkt_reader_pkg.sv | 31 +++
 rtl/ddr_pkt_reader_if.sv | 46 ++++
 rtl/ddr_pkt_reader_tkeep_gen.sv | 14 +
 rtl/ddr_pkt_reader.sv | 175 +++++++++++++++++
 tb/tb_ddr_pkt_reader.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_pkt_reader_pkg.sv
// Shared definitions for the DDR packet writer/reader pair: beat geometry, length
// limits, header length extraction and the reader FSM states.
package ddr_pkt_reader_pkg;

  localparam int         BEAT_BYTES = 64;
  localparam logic [2:0] SIZE_CODE  = 3'd6;
  localparam int         MIN_PKT    = 64;
  localparam int         MAX_PKT    = 1500;
  // Byte positions of the big-endian length field inside beat 0
  localparam int         LEN_MSB    = 16;
  localparam int         LEN_LSB    = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_AR,
    ST_HDR_R,
    ST_BODY_AR,
    ST_BODY_R,
    ST_ADVANCE,
    ST_HALT
  } rd_state_e;

  function automatic logic [15:0] pkt_len(input logic [7:0] msb_byte, input logic [7:0] lsb_byte);
    return {msb_byte, lsb_byte};
  endfunction

  function automatic logic [16:0] pkt_beats(input logic [15:0] len);
    return ({1'b0, len} + 17'd63) >> 6;
  endfunction

endpackage

// File: rtl/ddr_pkt_reader_if.sv
// AXI4 read channels plus the AXI-stream output of the DDR packet reader.
// master = the reader, slave = memory / stream sink side.
interface ddr_pkt_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4
);

  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [ID_WIDTH-1:0]     m_axi_rid;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
  logic                    m_axis_tlast;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/ddr_pkt_reader_tkeep_gen.sv
// Last-beat byte-enable mask from (packet length mod 64); combinational, no backpressure.
module ddr_pkt_reader_tkeep_gen
  import ddr_pkt_reader_pkg::*;
(
  input  logic [5:0]            rem_i,
  output logic [BEAT_BYTES-1:0] keep_o
);

  always_comb begin
    keep_o = '1;
    if (rem_i != 6'd0) keep_o = (BEAT_BYTES'(1) << rem_i) - BEAT_BYTES'(1);
  end

endmodule

// File: rtl/ddr_pkt_reader.sv
// Replays committed DDR packets onto AXI-stream: header read, body burst, one output stage.
// One beat/cycle when streaming; rready drops while the output register holds an unaccepted beat.
module ddr_pkt_reader
  import ddr_pkt_reader_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 512,
  parameter int                    ID_WIDTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    CREDIT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pkt_commit,
  ddr_pkt_reader_if.master        bus,
  output logic [CREDIT_WIDTH-1:0] pkts_pending,
  output logic                    err
);

  rd_state_e               state_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, araddr_q;
  logic [7:0]              arlen_q;
  logic                    arvalid_q;
  logic [15:0]             len_q;
  logic [16:0]             nbeats_q, beat_cnt_q;
  logic                    drain_q;
  logic                    tvalid_q, tlast_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [BEAT_BYTES-1:0]   tkeep_q;
  logic [CREDIT_WIDTH-1:0] pend_q;
  logic                    err_q;

  logic [15:0]           hdr_len;
  logic [16:0]           hdr_beats;
  logic                  hdr_bad, rready, r_acc, body_last, leave_idle;
  logic [5:0]            keep_rem;
  logic [BEAT_BYTES-1:0] last_keep;
  logic                  unused_rid;

  assign hdr_len    = pkt_len(bus.m_axi_rdata[LEN_MSB*8 +: 8], bus.m_axi_rdata[LEN_LSB*8 +: 8]);
  assign hdr_beats  = pkt_beats(hdr_len);
  assign hdr_bad    = (hdr_len < 16'(MIN_PKT)) || (hdr_len > 16'(MAX_PKT)) || (bus.m_axi_rresp != 2'b00);
  assign rready     = ((state_q == ST_HDR_R) || (state_q == ST_BODY_R)) && (!tvalid_q || bus.m_axis_tready);
  assign r_acc      = bus.m_axi_rvalid && rready;
  assign body_last  = (beat_cnt_q == nbeats_q - 17'd1);
  assign leave_idle = (state_q == ST_IDLE) && (pend_q != '0);
  assign keep_rem   = (state_q == ST_HDR_R) ? hdr_len[5:0] : len_q[5:0];
  assign unused_rid = ^bus.m_axi_rid;

  ddr_pkt_reader_tkeep_gen u_tkeep_gen (
    .rem_i  (keep_rem),
    .keep_o (last_keep)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= BASE_ADDR;
      araddr_q   <= BASE_ADDR;
      arlen_q    <= '0;
      arvalid_q  <= 1'b0;
      len_q      <= '0;
      nbeats_q   <= '0;
      beat_cnt_q <= '0;
      drain_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      // Commit and leave-IDLE in the same cycle cancel out
      if (pkt_commit && !leave_idle) begin
        if (pend_q == '1) err_q <= 1'b1;
        else              pend_q <= pend_q + 1'b1;
      end else if (!pkt_commit && leave_idle) begin
        pend_q <= pend_q - 1'b1;
      end

      if (tvalid_q && bus.m_axis_tready) tvalid_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (leave_idle) begin
            state_q   <= ST_HDR_AR;
            arvalid_q <= 1'b1;
            araddr_q  <= rd_addr_q;
            arlen_q   <= '0;
          end
        end
        ST_HDR_AR: begin
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_HDR_R;
          end
        end
        ST_HDR_R: begin
          if (r_acc) begin
            len_q    <= hdr_len;
            nbeats_q <= hdr_beats;
            if (hdr_bad) begin
              err_q   <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              tvalid_q   <= 1'b1;
              tdata_q    <= bus.m_axi_rdata;
              tlast_q    <= (hdr_beats == 17'd1);
              tkeep_q    <= (hdr_beats == 17'd1) ? last_keep : '1;
              beat_cnt_q <= 17'd1;
              if (hdr_beats == 17'd1) begin
                state_q <= ST_ADVANCE;
              end else begin
                state_q   <= ST_BODY_AR;
                arvalid_q <= 1'b1;
                araddr_q  <= rd_addr_q + ADDR_WIDTH'(BEAT_BYTES);
                arlen_q   <= 8'(hdr_beats - 17'd2);
              end
            end
          end
        end
        ST_BODY_AR: begin
          drain_q <= 1'b0;
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_BODY_R;
          end
        end
        ST_BODY_R: begin
          if (r_acc) begin
            // After an error response the rest of the burst is swallowed
            if ((bus.m_axi_rresp != 2'b00) || drain_q) begin
              err_q   <= 1'b1;
              drain_q <= 1'b1;
              if (bus.m_axi_rlast) state_q <= ST_HALT;
            end else if (bus.m_axi_rlast != body_last) begin
              err_q   <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              tvalid_q   <= 1'b1;
              tdata_q    <= bus.m_axi_rdata;
              tlast_q    <= body_last;
              tkeep_q    <= body_last ? last_keep : '1;
              beat_cnt_q <= beat_cnt_q + 17'd1;
              if (body_last) state_q <= ST_ADVANCE;
            end
          end
        end
        ST_ADVANCE: begin
          rd_addr_q <= rd_addr_q + (ADDR_WIDTH'(nbeats_q) << SIZE_CODE);
          state_q   <= ST_IDLE;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = SIZE_CODE;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tkeep  = tkeep_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign pkts_pending      = pend_q;
  assign err               = err_q;

endmodule

// File: tb/tb_ddr_pkt_reader.sv
// Bench for ddr_pkt_reader: small DDR model + stream sink, table of single-packet
// vectors and hand-written multi-packet / error sequences.
module tb_ddr_pkt_reader;

  localparam int AW = 32;
  localparam int DW = 512;
  localparam int IW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pkt_commit = 1'b0;
  logic [CW-1:0] pkts_pending;
  logic          err;

  ddr_pkt_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  ddr_pkt_reader #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .ID_WIDTH     (IW),
    .BASE_ADDR    ('0),
    .CREDIT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_commit   (pkt_commit),
    .bus          (bus),
    .pkts_pending (pkts_pending),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [511:0] data; logic [63:0] keep; logic last; } beat_t;
  typedef struct { int idx; logic last; logic [1:0] resp; } rbeat_t;
  typedef struct { int len; int beats; logic [63:0] last_keep; bit toggle; } vec_t;

  logic [511:0] mem [0:63];
  ar_t          ar_log[$];
  beat_t        out_q[$];
  rbeat_t       r_q[$];
  int           slverr_idx = -1;
  bit           tr_toggle = 1'b0;
  bit           tready_force0 = 1'b0;
  logic [3:0]   tr_pat = 4'b1001;
  int           tr_ph = 0;
  int           stab_viol, rdy_viol, stall_cnt;
  bit           hold_v;
  beat_t        hold_b;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Memory + sink model: drive at negedge, sample handshakes 1ns later
  initial begin
    bus.m_axi_arready = 1'b1;
    bus.m_axi_rid     = '0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      if (r_q.size() > 0) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = mem[r_q[0].idx];
        bus.m_axi_rresp  = r_q[0].resp;
        bus.m_axi_rlast  = r_q[0].last;
      end else begin
        bus.m_axi_rvalid = 1'b0;
      end
      bus.m_axis_tready = tready_force0 ? 1'b0 : (tr_toggle ? tr_pat[tr_ph % 4] : 1'b1);
      tr_ph++;
      #1;
      if (!rst) begin
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          ar_log.push_back('{addr: bus.m_axi_araddr, len: bus.m_axi_arlen});
          for (int i = 0; i <= int'(bus.m_axi_arlen); i++) begin
            int ix;
            ix = ((int'(bus.m_axi_araddr) >> 6) + i) % 64;
            r_q.push_back('{idx: ix, last: (i == int'(bus.m_axi_arlen)),
                            resp: (ix == slverr_idx) ? 2'b10 : 2'b00});
          end
        end
        if (bus.m_axi_rvalid && bus.m_axi_rready) void'(r_q.pop_front());
        if (bus.m_axis_tvalid && bus.m_axis_tready)
          out_q.push_back('{data: bus.m_axis_tdata, keep: bus.m_axis_tkeep, last: bus.m_axis_tlast});
        if (hold_v && !(bus.m_axis_tvalid && bus.m_axis_tdata == hold_b.data &&
                        bus.m_axis_tkeep == hold_b.keep && bus.m_axis_tlast == hold_b.last))
          stab_viol++;
        if (bus.m_axis_tvalid && !bus.m_axis_tready && bus.m_axi_rready) rdy_viol++;
        if (bus.m_axis_tvalid && !bus.m_axis_tready) stall_cnt++;
        hold_v = bus.m_axis_tvalid && !bus.m_axis_tready;
        hold_b = '{data: bus.m_axis_tdata, keep: bus.m_axis_tkeep, last: bus.m_axis_tlast};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pkt_commit = 1'b0;
    repeat (3) @(negedge clk);
    r_q.delete();
    ar_log.delete();
    out_q.delete();
    stab_viol = 0;
    rdy_viol  = 0;
    stall_cnt = 0;
    hold_v    = 1'b0;
    rst = 1'b0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 64; i++) mem[i] = {16{32'hA500_0000 | 32'(i)}};
  endtask

  task automatic place(input int idx, input int len);
    logic [15:0] l16;
    l16 = 16'(len);
    mem[idx][135:128] = l16[15:8];
    mem[idx][143:136] = l16[7:0];
  endtask

  task automatic commit(input int n);
    repeat (n) begin
      @(negedge clk);
      pkt_commit = 1'b1;
    end
    @(negedge clk);
    pkt_commit = 1'b0;
  endtask

  task automatic wait_beats(input string nm, input int n, input int budget);
    int c;
    c = 0;
    while (out_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (out_q.size() < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: got %0d beats, required %0d", nm, out_q.size(), n);
    end
  endtask

  task automatic wait_ars(input string nm, input int n, input int budget);
    int c;
    c = 0;
    while (ar_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (ar_log.size() < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: got %0d ARs, required %0d", nm, ar_log.size(), n);
    end
  endtask

  function automatic logic [63:0] keep_of(input int len);
    logic [63:0] k;
    int r;
    r = len % 64;
    k = '0;
    if (r == 0) k = '1;
    for (int b = 0; b < r; b++) k[b] = 1'b1;
    return k;
  endfunction

  // Checks ARs and stream beats of back-to-back packets stored from index 0
  task automatic verify(input int lens[$], output int next_idx);
    int idx, bi, ai, n;
    idx = 0; bi = 0; ai = 0;
    foreach (lens[p]) begin
      n = (lens[p] + 63) / 64;
      if (ai < ar_log.size()) begin
        chk("hdr_ar_addr", ar_log[ai].addr, 64'(idx * 64));
        chk("hdr_ar_len", ar_log[ai].len, 64'd0);
      end
      ai++;
      if (n > 1) begin
        if (ai < ar_log.size()) begin
          chk("body_ar_addr", ar_log[ai].addr, 64'(idx * 64 + 64));
          chk("body_ar_len", ar_log[ai].len, 64'(n - 2));
        end
        ai++;
      end
      for (int k = 0; k < n; k++) begin
        if (bi < out_q.size()) begin
          chkw("beat_data", out_q[bi].data, mem[idx + k]);
          chk("beat_keep", out_q[bi].keep, (k == n - 1) ? keep_of(lens[p]) : '1);
          chk("beat_last", 64'(out_q[bi].last), 64'(k == n - 1));
        end
        bi++;
      end
      idx += n;
    end
    chk("beat_count", out_q.size(), 64'(bi));
    chk("ar_count", ar_log.size(), 64'(ai));
    next_idx = idx;
  endtask

  task automatic probe_next(input int idx);
    int base;
    base = ar_log.size();
    commit(1);
    wait_ars("next_ar", base + 1, 100);
    if (ar_log.size() > base) chk("next_ar_addr", ar_log[base].addr, 64'(idx * 64));
  endtask

  vec_t vt[5];

  initial begin
    int lens[$];
    int nx;

    vt[0] = '{len: 64,   beats: 1,  last_keep: 64'hFFFF_FFFF_FFFF_FFFF, toggle: 1'b0};
    vt[1] = '{len: 100,  beats: 2,  last_keep: 64'h0000_000F_FFFF_FFFF, toggle: 1'b0};
    vt[2] = '{len: 129,  beats: 3,  last_keep: 64'h0000_0000_0000_0001, toggle: 1'b0};
    vt[3] = '{len: 1500, beats: 24, last_keep: 64'h0000_0000_0FFF_FFFF, toggle: 1'b0};
    vt[4] = '{len: 640,  beats: 10, last_keep: 64'hFFFF_FFFF_FFFF_FFFF, toggle: 1'b1};

    do_reset();
    #2;
    chk("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    chk("rst_araddr", bus.m_axi_araddr, 64'd0);
    chk("rst_arlen", bus.m_axi_arlen, 64'd0);
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
    chk("rst_tkeep", bus.m_axis_tkeep, 64'd0);
    chkw("rst_tdata", bus.m_axis_tdata, '0);
    chk("rst_pending", pkts_pending, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rready", 64'(bus.m_axi_rready), 64'd0);
    chk("rst_arsize", bus.m_axi_arsize, 64'd6);
    chk("rst_arburst", bus.m_axi_arburst, 64'd1);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      init_mem();
      place(0, vt[v].len);
      place(vt[v].beats, 64);
      tr_toggle = vt[v].toggle;
      tr_ph = 0;
      commit(1);
      wait_beats("vec_beats", vt[v].beats, 400);
      repeat (3) @(negedge clk);
      #2;
      chk("vec_pending", pkts_pending, 64'd0);
      chk("vec_err", 64'(err), 64'd0);
      if (out_q.size() >= vt[v].beats)
        chk("vec_last_keep", out_q[vt[v].beats - 1].keep, vt[v].last_keep);
      lens = '{vt[v].len};
      verify(lens, nx);
      chk("vec_next_idx", 64'(nx), 64'(vt[v].beats));
      chk("vec_stable", 64'(stab_viol), 64'd0);
      chk("vec_rready_full", 64'(rdy_viol), 64'd0);
      if (vt[v].toggle) chk("vec_stalled", 64'(stall_cnt > 0), 64'd1);
      probe_next(vt[v].beats);
      tr_toggle = 1'b0;
    end

    // Three back-to-back commits: 100/64/129 bytes at 0, 128, 192
    do_reset();
    init_mem();
    place(0, 100);
    place(2, 64);
    place(3, 129);
    place(6, 64);
    commit(3);
    wait_beats("multi_beats", 6, 400);
    repeat (3) @(negedge clk);
    #2;
    lens = '{100, 64, 129};
    verify(lens, nx);
    chk("multi_pending", pkts_pending, 64'd0);
    probe_next(6);

    // Undersized header halts with credits still pending
    do_reset();
    init_mem();
    place(0, 40);
    commit(3);
    repeat (30) @(negedge clk);
    #2;
    chk("short_err", 64'(err), 64'd1);
    chk("short_beats", out_q.size(), 64'd0);
    chk("short_ar_count", ar_log.size(), 64'd1);
    chk("short_pending", pkts_pending, 64'd2);
    chk("short_rready", 64'(bus.m_axi_rready), 64'd0);
    do_reset();
    #2;
    chk("short_rst_err", 64'(err), 64'd0);
    chk("short_rst_pending", pkts_pending, 64'd0);

    // SLVERR on the second body beat of a 5-beat body burst
    do_reset();
    init_mem();
    place(0, 350);
    slverr_idx = 2;
    commit(1);
    repeat (40) @(negedge clk);
    #2;
    chk("slverr_err", 64'(err), 64'd1);
    chk("slverr_beats", out_q.size(), 64'd2);
    if (out_q.size() >= 2) begin
      chkw("slverr_hdr_data", out_q[0].data, mem[0]);
      chkw("slverr_b1_data", out_q[1].data, mem[1]);
      chk("slverr_b1_last", 64'(out_q[1].last), 64'd0);
    end
    if (ar_log.size() >= 2) chk("slverr_body_arlen", ar_log[1].len, 64'd4);
    chk("slverr_drained", r_q.size(), 64'd0);
    commit(1);
    repeat (10) @(negedge clk);
    #2;
    chk("slverr_no_ar", ar_log.size(), 64'd2);
    chk("slverr_rready", 64'(bus.m_axi_rready), 64'd0);
    chk("slverr_pending", pkts_pending, 64'd1);
    slverr_idx = -1;

    // Credit saturation: stream stalled so only two packets ever leave IDLE
    do_reset();
    init_mem();
    place(0, 64);
    place(1, 64);
    tready_force0 = 1'b1;
    commit(257);
    #2;
    chk("sat_pending_max", pkts_pending, 64'd255);
    chk("sat_err_before", 64'(err), 64'd0);
    commit(1);
    #2;
    chk("sat_pending_hold", pkts_pending, 64'd255);
    chk("sat_err_after", 64'(err), 64'd1);
    chk("sat_stable", 64'(stab_viol), 64'd0);
    tready_force0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
